// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the 5-stage pipeline CPU.
// Conditions the brk/cont/step buttons (2-FF sync, debounce, rising-edge
// pulse), sequences RUN/HALT/STEP and drives the global pipeline enable.
// Also latches the halt cause and keeps the step and cycle counters that
// the debug display shows.
module cpu_run_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 32,
  parameter bit START_RUN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brk_btn,
  input  logic             cont_btn,
  input  logic             step_btn,
  input  logic [7:0]       step_n,
  input  logic             expt,
  output logic             pipe_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [7:0]       step_rem,
  output logic [CNT_W-1:0] cycle_cnt
);

  // Debounce counter only has to reach DEB_CYCLES-1 before the level flips.
  localparam int              DEB_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BRK  = 2'b01;
  localparam logic [1:0] CAUSE_EXPT = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  localparam state_e RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  // Button index: 0 = brk, 1 = cont, 2 = step.
  logic [2:0]       btn_raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       level_r;
  logic [2:0]       pulse_r;
  logic [DEB_W-1:0] deb_cnt_r [3];

  logic brk_p_s;
  logic cont_p_s;
  logic step_p_s;

  state_e     state_r;
  state_e     state_nxt_s;
  logic [1:0] cause_r;
  logic [1:0] cause_nxt_s;
  logic [7:0] step_rem_r;
  logic [7:0] step_rem_nxt_s;
  logic [CNT_W-1:0] cycle_cnt_r;

  logic resume_ok_s;
  logic pipe_en_s;
  logic halted_s;

  assign btn_raw_s = {step_btn, cont_btn, brk_btn};

  // Synchronize, debounce and edge-detect all three buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      level_r <= 3'b000;
      pulse_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            // Enough consecutive differing samples: accept the new level,
            // and pulse only when the accepted level rises.
            level_r[i]   <= sync2_r[i];
            deb_cnt_r[i] <= '0;
            pulse_r[i]   <= sync2_r[i];
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
            pulse_r[i]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[i] <= '0;
          pulse_r[i]   <= 1'b0;
        end
      end
    end
  end

  assign brk_p_s  = pulse_r[0];
  assign cont_p_s = pulse_r[1];
  assign step_p_s = pulse_r[2];

  // An exception halt cannot be resumed while the exception is still raised.
  assign resume_ok_s = !((cause_r == CAUSE_EXPT) && expt);

  // State, cause and step counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RESET_STATE;
      cause_r    <= CAUSE_NONE;
      step_rem_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      cause_r    <= cause_nxt_s;
      step_rem_r <= step_rem_nxt_s;
    end
  end

  // Next-state logic with exception > break > continue > step-done priority.
  always_comb begin
    state_nxt_s    = state_r;
    cause_nxt_s    = cause_r;
    step_rem_nxt_s = step_rem_r;
    case (state_r)
      ST_RUN: begin
        if (expt) begin
          state_nxt_s = ST_HALT;
          cause_nxt_s = CAUSE_EXPT;
        end else if (brk_p_s) begin
          state_nxt_s = ST_HALT;
          cause_nxt_s = CAUSE_BRK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (cont_p_s && resume_ok_s) begin
          state_nxt_s = ST_RUN;
          cause_nxt_s = CAUSE_NONE;
        end else if (step_p_s && resume_ok_s) begin
          state_nxt_s    = ST_STEP;
          cause_nxt_s    = CAUSE_NONE;
          step_rem_nxt_s = (step_n == 8'd0) ? 8'd1 : step_n;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_STEP: begin
        if (expt) begin
          state_nxt_s = ST_HALT;
          cause_nxt_s = CAUSE_EXPT;
        end else if (brk_p_s) begin
          state_nxt_s = ST_HALT;
          cause_nxt_s = CAUSE_BRK;
        end else if (cont_p_s) begin
          state_nxt_s    = ST_RUN;
          step_rem_nxt_s = 8'd0;
        end else if (step_rem_r <= 8'd1) begin
          // Last enabled cycle of the step (0 can only arise from corruption).
          state_nxt_s    = ST_HALT;
          cause_nxt_s    = CAUSE_STEP;
          step_rem_nxt_s = 8'd0;
        end else begin
          step_rem_nxt_s = step_rem_r - 8'd1;
        end
      end
      default: begin
        // Unreachable encoding: freeze the pipeline in a known state.
        state_nxt_s    = ST_HALT;
        cause_nxt_s    = CAUSE_NONE;
        step_rem_nxt_s = 8'd0;
      end
    endcase
  end

  // Decode pipeline enable and halted flag from the state register only.
  always_comb begin
    pipe_en_s = (state_r == ST_RUN) || (state_r == ST_STEP);
    halted_s  = (state_r == ST_HALT);
  end

  // Count every enabled pipeline cycle, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r <= '0;
    end else if (pipe_en_s) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign pipe_en    = pipe_en_s;
  assign halted     = halted_s;
  assign state      = state_r;
  assign halt_cause = cause_r;
  assign step_rem   = step_rem_r;
  assign cycle_cnt  = cycle_cnt_r;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/halt/single-step controller for the 5-stage pipeline CPU.
- Conditions the raw brk/cont/step board buttons (sync + debounce + edge detect).
- Sequences the core through RUN, HALT and STEP states and drives one global pipeline enable into PC and all pipeline registers.
- Latches the halt cause, including the ALU overflow exception, and exposes cycle and step counters for the debug display.

Parameters:
- DEB_CYCLES, 16: consecutive identical synchronized samples required to accept a new button level (>=2).
- CNT_W, 32: width of cycle_cnt.
- START_RUN, 1: 1 = leave reset in RUN; 0 = leave reset in HALT.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- brk_btn  input  1  raw break button, asynchronous.
- cont_btn  input  1  raw continue button, asynchronous.
- step_btn  input  1  raw step button, asynchronous.
- step_n  input  8  pipeline cycles to run per step press; 0 treated as 1; sampled on HALT->STEP.
- expt  input  1  exception level from hazard unit (overflow), synchronous to clk.
- pipe_en  output  1  global enable; 0 freezes PC and IF/ID, ID/EX, EX/MEM, MEM/WB.
- halted  output  1  high when state is HALT.
- state  output  2  00 RUN, 01 HALT, 10 STEP.
- halt_cause  output  2  00 none, 01 BRK, 10 EXPT, 11 STEP-done.
- step_rem  output  8  enabled cycles remaining in current step.
- cycle_cnt  output  CNT_W  count of cycles with pipe_en=1; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at edge) forces the following, all at once:
  - state = RUN if START_RUN else HALT; pipe_en = START_RUN; halted = !START_RUN.
  - halt_cause = 00, step_rem = 0, cycle_cnt = 0.
  - All sync/debounce registers cleared to 0; no pulse emitted on the first cycles after reset.
  - rst mid-step aborts the step.
- Button path, identical for each of the three buttons:
  - 2-FF synchronizer feeds a debounce counter.
  - Accepted level changes after DEB_CYCLES consecutive samples differ from the current accepted level; any matching sample resets the counter.
  - Rising edge of the accepted level gives a 1-cycle pulse (brk_p, cont_p, step_p). Falling edges give no pulse.
  - Latency from a stable raw press to pulse = 2 + DEB_CYCLES cycles.
- FSM transitions are evaluated each edge and take effect at the next edge.
- RUN:
  - expt=1 -> HALT, cause EXPT.
  - else brk_p -> HALT, cause BRK.
  - cont_p and step_p ignored.
- HALT:
  - expt ignored.
  - cont_p -> RUN and clear cause to 00. Ignored while halt_cause=EXPT and expt=1.
  - else step_p -> STEP with step_rem = max(step_n,1). Same EXPT/expt=1 gating as cont_p.
  - cont_p has priority over step_p in the same cycle.
- STEP:
  - Each cycle step_rem decrements by 1.
  - Priority: expt -> HALT (EXPT); brk_p -> HALT (BRK); cont_p -> RUN, step_rem=0; step_rem==1 -> HALT (STEP-done), step_rem=0.
  - step_p in STEP is ignored.
  - Exactly max(step_n,1) enabled cycles per step press absent interruption.
  - On the EXPT and BRK exits, step_rem holds its value.
- Outputs:
  - pipe_en = (state != HALT), decoded from the state register only; no combinational path from any input.
  - The exception cycle itself is enabled; the pipeline freezes on the cycle after expt is sampled.
  - halt_cause holds until the next exit from HALT.
- cycle_cnt increments on every edge where pipe_en=1, including the last STEP cycle, and wraps to 0 past all-ones.
- Simultaneous brk_p and expt in RUN/STEP: EXPT wins.

Test Plan:
- Release rst with START_RUN=1, DEB_CYCLES=4; hold brk_btn high 10 cycles -> pulse 6 cycles after press; pipe_en=0, state=01, halt_cause=01 one cycle later; cycle_cnt frozen.
- From HALT, step_n=3, press step -> pipe_en high exactly 3 cycles, step_rem 3,2,1, then HALT with cause=11; cycle_cnt +3. Repeat with step_n=0 -> exactly 1 cycle.
- In RUN, assert expt 1 cycle -> HALT cause=10. cont with expt still 1 -> ignored. Drop expt, cont -> RUN, cause=00.
- Raw brk_btn bouncing: toggles every 2 cycles for 20 cycles, then stable high -> exactly one brk_p, only after the bouncing ends.
- step_n=200, cont pulse at step_rem=150 -> RUN, step_rem=0. Separately, brk and expt in the same cycle -> cause=10.
- Preload cycle_cnt near wrap with CNT_W=4 -> counts 14,15,0,1. Assert rst mid-STEP -> RUN/HALT per START_RUN, counters 0.
